iq_integrate_dump: RTL

- Downstream of the I/Q mixer: consumes the mixer's signed inphase and quadrature product streams.
- Low-pass filters and decimates each stream with a boxcar integrate-and-dump over DECIM accepted samples.
- Presents decimated I/Q pairs through a valid/ready holding register to the magnitude/phase stage.
- Both channels share one sample counter, so I and Q dumps are always aligned.

---
 rtl/dsp_pkg.sv | 20 ++
 rtl/iq_accumulator.sv | 41 ++++
 rtl/iq_integrate_dump.sv | 96 +++++++++
 3 files changed

// File: rtl/dsp_pkg.sv
// Shared DSP types and helpers for the I/Q receive chain.
// Provides accumulator width sizing and the signed I/Q pair bundle.
package dsp_pkg;

  // Width needed to sum decim samples of dw bits with no overflow.
  function automatic int acc_width(input int dw, input int decim);
    return dw + $clog2(decim);
  endfunction

  localparam int IQ_DW    = 32;
  localparam int IQ_DECIM = 256;
  localparam int IQ_W     = acc_width(IQ_DW, IQ_DECIM);

  // Decimated I/Q pair handed to the magnitude/phase stage.
  typedef struct packed {
    logic signed [IQ_W-1:0] i;
    logic signed [IQ_W-1:0] q;
  } iq_pair_t;

endpackage

// File: rtl/iq_accumulator.sv
// One signed integrate-and-dump channel driven by a shared strobe.
// Ports: clk, reset_n (sync, active-low), clear, accept, dump,
// sample (DW signed in), sum (ACC_W signed dump result).
module iq_accumulator #(
  parameter int DW    = 32,
  parameter int ACC_W = 40
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             accept,
  input  logic             dump,
  input  logic [DW-1:0]    sample,
  output logic [ACC_W-1:0] sum
);

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] ext;
  logic signed [ACC_W-1:0] nxt;

  assign ext = {{(ACC_W-DW){sample[DW-1]}}, sample};
  assign nxt = acc + ext;

  // sum keeps its value across clear; only validity is dropped.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc <= '0;
      sum <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (accept) begin
      if (dump) begin
        sum <= nxt;
        acc <= '0;
      end else begin
        acc <= nxt;
      end
    end
  end

endmodule

// File: rtl/iq_integrate_dump.sv
// Boxcar integrate-and-dump decimator for mixer I/Q products.
// Ports: clk, reset_n, clear, in_valid/in_i/in_q, out_valid,
// out_ready, out_i/out_q (ACC_W signed sums), overrun (sticky).
module iq_integrate_dump
  import dsp_pkg::*;
#(
  parameter int DW    = 32,
  parameter int DECIM = 256,
  parameter int ACC_W = acc_width(DW, DECIM)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [DW-1:0]    in_i,
  input  logic [DW-1:0]    in_q,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_i,
  output logic [ACC_W-1:0] out_q,
  output logic             overrun
);

  localparam int CW = $clog2(DECIM);

  logic [CW-1:0] cnt;
  logic          last;
  logic          accept;
  logic          dump;

  assign last   = (cnt == CW'(DECIM - 1));
  assign accept = in_valid & ~clear;
  assign dump   = accept & last;

  // One counter for both channels keeps I and Q dumps aligned.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= last ? '0 : cnt + 1'b1;
    end
  end

  // A dump re-asserts valid even when the old dump is consumed.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
    end else if (clear) begin
      out_valid <= 1'b0;
    end else if (dump) begin
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Overrun flags a dump landing on an unconsumed output.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      overrun <= 1'b0;
    end else if (clear) begin
      overrun <= 1'b0;
    end else if (dump && out_valid && !out_ready) begin
      overrun <= 1'b1;
    end
  end

  iq_accumulator #(
    .DW    (DW),
    .ACC_W (ACC_W)
  ) u_acc_i (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear),
    .accept  (accept),
    .dump    (dump),
    .sample  (in_i),
    .sum     (out_i)
  );

  iq_accumulator #(
    .DW    (DW),
    .ACC_W (ACC_W)
  ) u_acc_q (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear),
    .accept  (accept),
    .dump    (dump),
    .sample  (in_q),
    .sum     (out_q)
  );

endmodule
